// File: rtl/justtest1_v1_0_s00_axi_regs_if.sv
// AXI4-Lite bus bundle between the justtest1 master and the register-bank slave.
// Every channel transfers on a rising edge where valid and ready are both 1; valid never waits on ready.
interface justtest1_v1_0_s00_axi_regs_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/justtest1_v1_0_s00_axi_regs.sv
// AXI4-Lite slave register bank with independent write/read FSMs and flat register export.
// Optional JUSTTEST1_WR_PULSE_EN adds a one-cycle per-register write strobe output.
module justtest1_v1_0_s00_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                                S_AXI_ACLK,
   input  logic                                S_AXI_ARESET,
   justtest1_v1_0_s00_axi_regs_if.slave        s_axi,
   output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] slv_regs_o,
`ifdef JUSTTEST1_WR_PULSE_EN
   output logic [NUM_REGS-1:0]                 wr_pulse_o,
`endif
   output logic [1:0]                          wr_state_dbg,
   output logic                                rd_state_dbg
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic [DW-1:0]   regs [NUM_REGS];
   logic [IW-1:0]   aw_idx_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;

   logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit;
   logic [IW-1:0]   wr_idx, rd_idx;
   logic [DW-1:0]   wr_data, rd_word;
   logic [DW/8-1:0] wr_strb;
   logic            wr_ok, rd_ok;
   logic            unused_ok;

   assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   assign aw_hs = s_axi.awvalid & s_axi.awready;
   assign w_hs  = s_axi.wvalid  & s_axi.wready;
   assign b_hs  = s_axi.bvalid  & s_axi.bready;
   assign ar_hs = s_axi.arvalid & s_axi.arready;
   assign r_hs  = s_axi.rvalid  & s_axi.rready;

   // The half that completes the pair comes straight off the bus; the other half was latched earlier.
   assign wr_idx  = aw_hs ? s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
   assign wr_data = w_hs ? s_axi.wdata : wdata_q;
   assign wr_strb = w_hs ? s_axi.wstrb : wstrb_q;
   assign wr_ok   = 32'(wr_idx) < NUM_REGS;
   assign rd_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_ok   = 32'(rd_idx) < NUM_REGS;

   assign wr_state_dbg = wr_state;
   assign rd_state_dbg = (rd_state == R_DATA);

   always_comb begin
      wr_next   = wr_state;
      wr_commit = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_next   = W_RESP;
               wr_commit = 1'b1;
            end else if (aw_hs) begin
               wr_next = W_HAVE_AW;
            end else if (w_hs) begin
               wr_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_hs) begin
            wr_next   = W_RESP;
            wr_commit = 1'b1;
         end
         W_HAVE_W: if (aw_hs) begin
            wr_next   = W_RESP;
            wr_commit = 1'b1;
         end
         W_RESP: if (b_hs) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs) rd_next = R_DATA;
         R_DATA:  if (r_hs)  rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (32'(rd_idx) == k) rd_word = regs[k];
      end
   end

   // Readys and valids are registered from the next state so every bus output comes off a flop.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_state      <= W_IDLE;
         rd_state      <= R_IDLE;
         s_axi.awready <= 1'b0;
         s_axi.wready  <= 1'b0;
         s_axi.bvalid  <= 1'b0;
         s_axi.bresp   <= RESP_OKAY;
         s_axi.arready <= 1'b0;
         s_axi.rvalid  <= 1'b0;
         s_axi.rdata   <= '0;
         s_axi.rresp   <= RESP_OKAY;
         aw_idx_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
      end else begin
         wr_state      <= wr_next;
         rd_state      <= rd_next;
         s_axi.awready <= (wr_next == W_IDLE) || (wr_next == W_HAVE_W);
         s_axi.wready  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_AW);
         s_axi.bvalid  <= (wr_next == W_RESP);
         s_axi.arready <= (rd_next == R_IDLE);
         s_axi.rvalid  <= (rd_next == R_DATA);
         if (wr_commit) s_axi.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (ar_hs) begin
            s_axi.rdata <= rd_word;
            s_axi.rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (aw_hs) aw_idx_q <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_hs) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      for (int k = 0; k < NUM_REGS; k++) begin
         if (S_AXI_ARESET) begin
            regs[k] <= '0;
         end else if (wr_commit && wr_ok && 32'(wr_idx) == k) begin
            for (int b = 0; b < DW/8; b++) begin
               if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) slv_regs_o[DW*k +: DW] = regs[k];
   end

`ifdef JUSTTEST1_WR_PULSE_EN
   // Strobe fires even for an all-zero WSTRB; an out-of-range write never fires it.
   always_ff @(posedge S_AXI_ACLK) begin
      for (int k = 0; k < NUM_REGS; k++) begin
         if (S_AXI_ARESET) wr_pulse_o[k] <= 1'b0;
         else              wr_pulse_o[k] <= wr_commit && wr_ok && (32'(wr_idx) == k);
      end
   end
`endif
endmodule

// File: tb/tb_justtest1_v1_0_s00_axi_regs.sv
// Directed bench for the AXI4-Lite register bank: ordering, strobes, back-pressure, collisions, errors, reset.
module tb_justtest1_v1_0_s00_axi_regs;
  localparam int AW = 5;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  justtest1_v1_0_s00_axi_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();
  logic [32*NR-1:0] slv_regs;
  logic [1:0]       wr_state_dbg;
  logic             rd_state_dbg;
`ifdef JUSTTEST1_WR_PULSE_EN
  logic [NR-1:0]    wr_pulse;
`endif

  justtest1_v1_0_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .s_axi(bus),
    .slv_regs_o(slv_regs),
`ifdef JUSTTEST1_WR_PULSE_EN
    .wr_pulse_o(wr_pulse),
`endif
    .wr_state_dbg(wr_state_dbg),
    .rd_state_dbg(rd_state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rdata;
  logic [1:0]  resp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int k);
    return slv_regs[32*k +: 32];
  endfunction

  task automatic idle_bus();
    bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] bresp);
    int budget;
    logic aw_go, w_go;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    budget = 0;
    while ((bus.awvalid || bus.wvalid) && budget < 20) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
      budget++;
    end
    if (bus.awvalid || bus.wvalid) begin
      check("write_addr_timeout", 32'd1, 32'd0);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    bus.bready = 1'b1;
    budget = 0;
    while (!bus.bvalid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.bvalid) check("write_resp_timeout", 32'd1, 32'd0);
    bresp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] rresp);
    int budget;
    logic ar_go;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    budget = 0;
    while (bus.arvalid && budget < 20) begin
      ar_go = bus.arready;
      @(negedge clk);
      if (ar_go) bus.arvalid = 1'b0;
      budget++;
    end
    if (bus.arvalid) begin
      check("read_addr_timeout", 32'd1, 32'd0);
      bus.arvalid = 1'b0;
    end
    bus.rready = 1'b1;
    budget = 0;
    while (!bus.rvalid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.rvalid) check("read_data_timeout", 32'd1, 32'd0);
    data  = bus.rdata;
    rresp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    // clock/reset block
    rst = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    for (int k = 0; k < NR; k++) check("rst_reg", reg_at(k), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

    // basic writes then readback through the expected queue
    for (int k = 0; k < NR; k++) begin
      axi_write(AW'(4*k), 32'(k + 1), 4'hF, resp);
      check("t1_bresp", 32'(resp), 32'd0);
      exp_q.push_back(32'(k + 1));
    end
    for (int k = 0; k < NR; k++) begin
      axi_read(AW'(4*k), rdata, resp);
      check("t1_rdata", rdata, exp_q.pop_front());
      check("t1_rresp", 32'(resp), 32'd0);
    end

    // W three cycles ahead of AW
    bus.wdata = 32'hA5A50001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("t2_have_w", 32'(wr_state_dbg), 32'd2);
    repeat (2) @(negedge clk);
    check("t2_no_b_early", 32'(bus.bvalid), 32'd0);
    bus.awaddr = 5'h08; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("t2_bvalid_lat", 32'(bus.bvalid), 32'd1);
    check("t2_reg2", reg_at(2), 32'hA5A50001);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    // AW three cycles ahead of W
    bus.awaddr = 5'h0C; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("t2_have_aw", 32'(wr_state_dbg), 32'd1);
    repeat (2) @(negedge clk);
    check("t2_no_b_early2", 32'(bus.bvalid), 32'd0);
    bus.wdata = 32'h5A5A0003; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("t2_bvalid_lat2", 32'(bus.bvalid), 32'd1);
    check("t2_bresp2", 32'(bus.bresp), 32'd0);
    check("t2_reg3", reg_at(3), 32'h5A5A0003);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;

    // byte strobes
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, resp);
    axi_write(5'h04, 32'h11223344, 4'b0101, resp);
    axi_read(5'h04, rdata, resp);
    check("t3_strobe", rdata, 32'hAA22CC44);

    // B back-pressure
    bus.awaddr = 5'h00; bus.awvalid = 1'b1;
    bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", 32'({bus.bvalid, bus.awready, bus.wready}), 32'b100);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t4_b_done", 32'(bus.bvalid), 32'd0);
    check("t4_reg0", reg_at(0), 32'h77);
    // R back-pressure while the same register is rewritten
    bus.araddr = 5'h00; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("t4_rdata_first", bus.rdata, 32'h77);
    axi_write(5'h00, 32'h99, 4'hF, resp);
    check("t4_rdata_stable", bus.rdata, 32'h77);
    check("t4_rvalid_held", 32'(bus.rvalid), 32'd1);
    check("t4_reg0_new", reg_at(0), 32'h99);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("t4_r_done", 32'(bus.rvalid), 32'd0);

    // AR and write commit on the same edge
    axi_write(5'h00, 32'h1, 4'hF, resp);
    bus.awaddr = 5'h00; bus.awvalid = 1'b1;
    bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 5'h00; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("t5_old_data", bus.rdata, 32'h1);
    check("t5_both_valid", 32'({bus.rvalid, bus.bvalid}), 32'b11);
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(5'h00, rdata, resp);
    check("t5_new_data", rdata, 32'h55);

    // out-of-range index
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, resp);
    check("err_bresp", 32'(resp), 32'd2);
    check("err_reg0", reg_at(0), 32'h55);
    check("err_reg1", reg_at(1), 32'hAA22CC44);
    axi_read(5'h14, rdata, resp);
    check("err_rdata", rdata, 32'h0);
    check("err_rresp", 32'(resp), 32'd2);

`ifdef JUSTTEST1_WR_PULSE_EN
    check("pulse_idle", 32'(wr_pulse), 32'd0);
    bus.awaddr = 5'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'h1234; bus.wstrb = 4'h0; bus.wvalid = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("pulse_on", 32'(wr_pulse), 32'b0100);
    @(negedge clk);
    check("pulse_off", 32'(wr_pulse), 32'd0);
    bus.awaddr = 5'h10; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("pulse_slverr", 32'(wr_pulse), 32'd0);
    @(negedge clk);
    bus.bready = 1'b0;
`endif

    // reset in the middle of a write and a read
    bus.awaddr = 5'h04; bus.awvalid = 1'b1;
    bus.araddr = 5'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    check("t6_have_aw", 32'(wr_state_dbg), 32'd1);
    check("t6_rdata", bus.rdata, 32'hAA22CC44);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valids", 32'({bus.bvalid, bus.rvalid}), 32'd0);
    check("t6_states", 32'({wr_state_dbg, rd_state_dbg}), 32'd0);
    check("t6_rdata_clr", bus.rdata, 32'h0);
    for (int k = 0; k < NR; k++) check("t6_reg_clr", reg_at(k), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
    check("t6_no_b", 32'(bus.bvalid), 32'd0);
    axi_write(5'h04, 32'h42, 4'hF, resp);
    axi_read(5'h04, rdata, resp);
    check("t6_after", rdata, 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
